// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: state encoding and default widths shared by the scan
// sequencer, its interface and its bench.
package scan_ctrl_pkg;

    localparam int STATE_W    = 2;
    localparam int ADDR_W_DEF = 10;
    localparam int LEN_W_DEF  = 10;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/scan_ctrl_if.sv
// scan_ctrl_if: command (start/base/len), consumer handshake and status
// signals of the scan sequencer. The abort line exists only when
// SCAN_CTRL_ABORT_EN is defined.
interface scan_ctrl_if
    import scan_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) ();

    logic              start;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic              ready;
`ifdef SCAN_CTRL_ABORT_EN
    logic              abort;
`endif
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              busy;
    logic              done;

    // Controller/consumer side: issues commands, accepts beats.
    modport master (
        output start, base, len, ready,
`ifdef SCAN_CTRL_ABORT_EN
        output abort,
`endif
        input  valid, addr, last, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, base, len, ready,
`ifdef SCAN_CTRL_ABORT_EN
        input  abort,
`endif
        output valid, addr, last, busy, done
    );

endinterface

// File: rtl/clr_counter.sv
// clr_counter: W-bit up counter, increment built as a half-adder ripple
// chain; synchronous clear has priority over the enable.
module clr_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] inc;
    logic [W-1:0] carry;

    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign inc[i] = q[i] ^ carry[i];
            // The carry out of the top bit is dropped: callers never wrap.
            if (i < W-1) begin : g_c
                assign carry[i+1] = q[i] & carry[i];
            end
        end
    endgenerate

    // Enable register with clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= inc;
    end

endmodule

// File: rtl/ripple_add.sv
// ripple_add: W-bit full-adder ripple chain, result truncated to W bits
// (wrap-around is the intended behaviour for address generation).
module ripple_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] carry;

    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign sum[i] = a[i] ^ b[i] ^ carry[i];
            if (i < W-1) begin : g_c
                assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
            end
        end
    endgenerate

endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: issues len addresses from base, one per valid/ready beat, then
// pulses done. Optional early termination via abort when SCAN_CTRL_ABORT_EN
// is defined. All outputs decode registered state only.
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    scan_ctrl_if.slave  bus
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] addr_sum;
    logic              load, beat, at_last, idx_inc;
    logic              valid, last, busy, done;
    logic [ADDR_W-1:0] addr;

    assign load    = (state == IDLE) && bus.start;
    // len_q is at least 1 whenever RUN is reachable, so len_q-1 never wraps there.
    assign at_last = (idx == len_q - LEN_W'(1));
    assign beat    = (state == RUN) && bus.ready;
    // idx freezes on the final beat so it stays below len_q and cannot overflow.
    assign idx_inc = beat && !at_last;

    // Command capture; later changes to base/len are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
        end else if (load) begin
            base_q <= bus.base;
            len_q  <= bus.len;
        end
    end

    clr_counter #(.W(LEN_W)) u_idx (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  (idx_inc),
        .q   (idx)
    );

    ripple_add #(.W(ADDR_W)) u_addr (
        .a   (base_q),
        .b   (ADDR_W'(idx)),
        .sum (addr_sum)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and output decode.
    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        addr      = '0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = (bus.len == '0) ? DONE : RUN;
            end
            RUN: begin
                valid = 1'b1;
                busy  = 1'b1;
                addr  = addr_sum;
                last  = at_last;
                if (beat && at_last) state_nxt = DONE;
`ifdef SCAN_CTRL_ABORT_EN
                // A beat in the abort cycle still counts; it was already accepted.
                if (bus.abort) state_nxt = DONE;
`endif
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.valid = valid;
    assign bus.addr  = addr;
    assign bus.last  = last;
    assign bus.busy  = busy;
    assign bus.done  = done;

endmodule
